// File: rtl/ram_port_arb.sv
// ============================================================================
// Module   : ram_port_arb
// Brief    : Round-robin arbiter sharing one block-RAM port among NREQ
//            requesters, with registered per-requester read-valid strobes.
//            Optional burst lock: define RAM_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_port_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 13,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      ram_a,
    output logic [DW-1:0]      ram_di,
    output logic               ram_ce,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_do
);

    localparam int c_pw = (NREQ > 2) ? 2 : 1;

    if (NREQ < 2 || NREQ > 4) begin : g_nreq_range
        $error("ram_port_arb: NREQ must be in the range 2..4");
    end

    logic [c_pw-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [c_pw-1:0] w_win;
    logic            w_any;

    function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] v);
        return (v == c_pw'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // First eligible requester at or after the priority pointer, wrapping.
    always_comb begin : p_search
        int              idx;
        logic [c_pw-1:0] idx_v;
        idx   = 0;
        idx_v = '0;
        w_gnt = '0;
        w_win = '0;
        w_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = c_pw'(idx);
            if (!w_any && w_elig[idx_v]) begin
                w_any = 1'b1;
                w_win = idx_v;
            end
        end
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
    end

`ifdef RAM_ARB_LOCK_EN
    logic            owner_vld_q, owner_vld_d;
    logic [c_pw-1:0] owner_q, owner_d;
    logic [NREQ-1:0] w_owner_mask;

    always_comb begin : p_elig
        w_owner_mask          = '0;
        w_owner_mask[owner_q] = 1'b1;
        if (rst) begin
            w_elig = '0;
        end else if (owner_vld_q) begin
            w_elig = req & w_owner_mask;
        end else begin
            w_elig = req;
        end
    end

    // The pointer is frozen while a burst owns the port and jumps past the
    // owner when it lets go, so a lock never skews round-robin fairness.
    always_comb begin : p_owner
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        if (owner_vld_q) begin
            if (!req[owner_q] || (w_any && !lock[owner_q])) begin
                owner_vld_d = 1'b0;
                ptr_d       = f_next(owner_q);
            end
        end else if (w_any) begin
            if (lock[w_win]) begin
                owner_vld_d = 1'b1;
                owner_d     = w_win;
            end else begin
                ptr_d = f_next(w_win);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end
`else
    logic w_lock_unused;
    assign w_lock_unused = ^lock;

    always_comb begin : p_elig
        w_elig = rst ? '0 : req;
        ptr_d  = w_any ? f_next(w_win) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // RAM read latency is one cycle, so the strobe is simply the read grant delayed.
    always_comb begin : p_rvalid
        rvalid_d = (w_any && !we[w_win]) ? w_gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt    = w_gnt;
    assign ram_ce = w_any;
    assign ram_we = w_any & we[w_win];
    assign ram_a  = addr[int'(w_win)*AW +: AW];
    assign ram_di = din[int'(w_win)*DW +: DW];
    assign rvalid = rvalid_q;
    assign rdata  = ram_do;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arb.sv
// ============================================================================
// Module   : tb_ram_port_arb
// Brief    : Directed bench for ram_port_arb with a read-first RAM model and a
//            scoreboard that checks read returns independently of the driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arb;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [2:0]  req    = '0;
    logic [2:0]  we     = '0;
    logic [2:0]  lock   = '0;
    logic [38:0] addr   = '0;
    logic [47:0] din    = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic [12:0] ram_a;
    logic [15:0] ram_di;
    logic        ram_ce;
    logic        ram_we;
    logic [15:0] ram_do = '0;

    ram_port_arb #(.NREQ(3), .AW(13), .DW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .lock   (lock),
        .addr   (addr),
        .din    (din),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .ram_a  (ram_a),
        .ram_di (ram_di),
        .ram_ce (ram_ce),
        .ram_we (ram_we),
        .ram_do (ram_do)
    );

    always #5 clk = ~clk;

    // Read-first 8K x 16 RAM; every word preloads to 0x4000 + address.
    logic [15:0] mem [8192];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 8192; a++) begin
                mem[a] <= 16'h4000 + 16'(a);
            end
            loaded <= 1'b1;
        end else if (ram_ce) begin
            ram_do <= mem[ram_a];
            if (ram_we) begin
                mem[ram_a] <= ram_di;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [2:0]  rv;
        logic [15:0] rd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One bus cycle: drive after the edge, check the combinational grant at the
    // falling edge, and queue the read return expected on the following cycle.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] wv,
                        input logic [2:0] lk, input logic [12:0] a0, input logic [12:0] a1,
                        input logic [12:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [2:0] eg, input logic [15:0] ed);
        logic [12:0] ea;
        logic [15:0] edi;
        exp_t        e;
        @(posedge clk);
        #1;
        rst  = r;
        req  = rq;
        we   = wv;
        lock = lk;
        addr = {a2, a1, a0};
        din  = {16'hDEAD, d1, d0};
        @(negedge clk);
        chk("gnt", 48'(gnt), 48'(eg));
        chk("ram_ce", 48'(ram_ce), 48'(|eg));
        chk("ram_we", 48'(ram_we), 48'(|(eg & wv)));
        if (eg != 3'b000) begin
            ea  = eg[0] ? a0 : (eg[1] ? a1 : a2);
            edi = eg[0] ? d0 : (eg[1] ? d1 : 16'hDEAD);
            chk("ram_a", 48'(ram_a), 48'(ea));
            if ((eg & wv) != 3'b000) begin
                chk("ram_di", 48'(ram_di), 48'(edi));
            end else begin
                e.due = cyc + 1;
                e.rv  = eg;
                e.rd  = ed;
                q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: any rvalid must match the head of the queue on its due cycle.
    always begin
        @(posedge clk);
        #3;
        if (q.size() > 0 && q[0].due == cyc) begin
            mon_e = q.pop_front();
            chk("rvalid", 48'(rvalid), 48'(mon_e.rv));
            chk("rdata", 48'(rdata), 48'(mon_e.rd));
        end else if (rvalid !== 3'b000) begin
            chk("rvalid_unexpected", 48'(rvalid), 48'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    localparam logic [12:0] A0 = 13'h0010;
    localparam logic [12:0] A1 = 13'h0123;
    localparam logic [12:0] A2 = 13'h1ABC;

    initial begin
        // Reset with every requester active: nothing may reach the RAM.
        step(1'b1, 3'b111, 3'b111, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b000, 16'h0);
        chk("reset_rvalid", 48'(rvalid), 48'(0));
        step(1'b1, 3'b111, 3'b111, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b000, 16'h0);
        chk("reset_rvalid", 48'(rvalid), 48'(0));

        // Full contention, all reads: strict rotation with pipelined returns.
        for (int n = 0; n < 2; n++) begin
            step(1'b0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b001, 16'h4010);
            step(1'b0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b010, 16'h4123);
            step(1'b0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b100, 16'h5ABC);
        end

        // Write then read of the top word by the same requester.
        step(1'b0, 3'b010, 3'b010, 3'b000, A0, 13'h1FFF, A2, 16'h0, 16'hA5C3, 3'b010, 16'h0);
        step(1'b0, 3'b010, 3'b000, 3'b000, A0, 13'h1FFF, A2, 16'h0, 16'h0, 3'b010, 16'hA5C3);

        // Lone requester gets back-to-back grants.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'b100, 3'b000, 3'b000, A0, A1, 13'(k), 16'h0, 16'h0,
                 3'b100, 16'h4000 + 16'(k));
        end

        // Read granted, then reset hits the commit edge: the return is dropped.
        step(1'b0, 3'b001, 3'b000, 3'b000, 13'h0005, A1, A2, 16'h0, 16'h0, 3'b001, 16'h4005);
        void'(q.pop_back());
        rst = 1'b1;
        step(1'b1, 3'b000, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b000, 16'h0);
        chk("rst_drops_rvalid", 48'(rvalid), 48'(0));
        // Pointer back at 0: requester 0 beats requester 2.
        step(1'b0, 3'b101, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b001, 16'h4010);
        step(1'b0, 3'b100, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b100, 16'h5ABC);

        // Requester 0 writes a three-word burst while requester 1 keeps reading.
`ifdef RAM_ARB_LOCK_EN
        step(1'b0, 3'b011, 3'b001, 3'b001, 13'h0100, 13'h0200, A2, 16'h1111, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b011, 3'b001, 3'b001, 13'h0101, 13'h0200, A2, 16'h2222, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b011, 3'b001, 3'b000, 13'h0102, 13'h0200, A2, 16'h3333, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b010, 3'b000, 3'b000, A0, 13'h0200, A2, 16'h0, 16'h0, 3'b010, 16'h4200);
`else
        step(1'b0, 3'b011, 3'b001, 3'b001, 13'h0100, 13'h0200, A2, 16'h1111, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b011, 3'b001, 3'b001, 13'h0101, 13'h0200, A2, 16'h2222, 16'h0, 3'b010, 16'h4200);
        step(1'b0, 3'b011, 3'b001, 3'b001, 13'h0101, 13'h0200, A2, 16'h2222, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b011, 3'b001, 3'b000, 13'h0102, 13'h0200, A2, 16'h3333, 16'h0, 3'b010, 16'h4200);
        step(1'b0, 3'b011, 3'b001, 3'b000, 13'h0102, 13'h0200, A2, 16'h3333, 16'h0, 3'b001, 16'h0);
        step(1'b0, 3'b010, 3'b000, 3'b000, A0, 13'h0200, A2, 16'h0, 16'h0, 3'b010, 16'h4200);
`endif

        // Read the burst back through requester 2.
        step(1'b0, 3'b100, 3'b000, 3'b000, A0, A1, 13'h0100, 16'h0, 16'h0, 3'b100, 16'h1111);
        step(1'b0, 3'b100, 3'b000, 3'b000, A0, A1, 13'h0101, 16'h0, 16'h0, 3'b100, 16'h2222);
        step(1'b0, 3'b100, 3'b000, 3'b000, A0, A1, 13'h0102, 16'h0, 16'h0, 3'b100, 16'h3333);
        step(1'b0, 3'b000, 3'b000, 3'b000, A0, A1, A2, 16'h0, 16'h0, 3'b000, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 48'(q.size()), 48'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
